alu_cmd_fifo: RTL



---
 rtl/alu_cmd_fifo.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Command-driven ALU with a DEPTH-entry result FIFO. Single-cycle
//               ops push at the accept edge; POW runs on an iterative
//               multiplier FSM and pushes once its exponent count reaches 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int EXPW  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_ASHR = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_MIN  = 4'd8;
  localparam logic [3:0] OP_RED  = 4'd9;
  localparam logic [3:0] OP_POW  = 4'd10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_POW  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] pow_a;
  logic [WIDTH-1:0] acc;
  logic [EXPW-1:0]  cnt;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_err  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             accept;
  logic             start_pow;
  logic             pow_done;
  logic             push;
  logic             pop;
  logic [WIDTH:0]   single_res;
  logic [WIDTH-1:0] push_data;
  logic             push_err;

  // Result of every single-cycle opcode as {err, data}; SV shift semantics
  // already give 0 (logical) or sign fill (arithmetic) for oversize amounts.
  function automatic logic [WIDTH:0] alu_single(input logic [3:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             e;
    r = '0;
    e = 1'b0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_SHL:  r = a << b;
      OP_SHR:  r = a >> b;
      OP_ASHR: r = $signed(a) >>> b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = a ~^ b;
      OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
      OP_RED:  r = {{(WIDTH-3){1'b0}}, &a, |a, ^a};
      OP_POW:  r = '0;
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  // in_ready deliberately ignores out_ready so there is no comb path through.
  assign in_ready   = (state == S_IDLE) && (count < CW'(DEPTH));
  assign accept     = in_valid && in_ready;
  assign start_pow  = accept && (in_op == OP_POW);
  assign pow_done   = (state == S_POW) && (cnt == '0);
  assign single_res = alu_single(in_op, in_a, in_b);
  assign push       = (accept && (in_op != OP_POW)) || pow_done;
  assign push_data  = pow_done ? acc : single_res[WIDTH-1:0];
  assign push_err   = pow_done ? 1'b0 : single_res[WIDTH];
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? mem_data[rd_ptr] : '0;
  assign out_err    = out_valid ? mem_err[rd_ptr] : 1'b0;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and busy flag.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      S_IDLE: if (start_pow) state_nxt = S_POW;
      S_POW: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // POW datapath: load on accept, then one multiply per cycle until cnt hits 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pow_a <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start_pow) begin
      pow_a <= in_a;
      acc   <= WIDTH'(1);
      cnt   <= in_b[EXPW-1:0];
    end else if ((state == S_POW) && (cnt != '0)) begin
      acc   <= acc * pow_a;
      cnt   <= cnt - EXPW'(1);
    end
  end

  // FIFO storage; contents need no reset because out_data/out_err are gated.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_err[wr_ptr]  <= push_err;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire
